prefetch_queue: RTL and testbench

//   Buffers prefetch candidates emitted by the ISB (one per cycle: valid + 16-bit addr) and issues them
//   to the memory side under a valid/ready handshake. Drops duplicates already queued, squashes entries

---
 rtl/prefetch_queue_pkg.sv | 14 +
 rtl/prefetch_queue_cam.sv | 20 ++
 rtl/prefetch_queue.sv | 142 ++++++++++++++
 tb/tb_prefetch_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/prefetch_queue_pkg.sv
// Shared constants and helpers for the prefetch queue.
// The optional PFQ_STATS_EN statistics counters use STAT_W from here.
package prefetch_queue_pkg;

  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned STAT_W     = 16;

  // Pointer width for a power-of-two depth; at least one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/prefetch_queue_cam.sv
// DEPTH-way equality compare of one key against the slot addresses.
// Only valid slots can hit; the result is one hit bit per slot.
module prefetch_queue_cam #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] key_i,
  input  logic [ADDR_W-1:0] slot_addr_i [DEPTH],
  input  logic [DEPTH-1:0]  slot_valid_i,
  output logic [DEPTH-1:0]  hit_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_o[i] = slot_valid_i[i] && (slot_addr_i[i] == key_i);
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Circular prefetch queue: duplicate/demand filtering, demand squash, valid/ready issue.
// Define PFQ_STATS_EN to add saturating dup_drops / full_drops / squashes counters.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pf_v,
  input  logic [ADDR_W-1:0] pf_addr,
  input  logic              dem_v,
  input  logic [ADDR_W-1:0] dem_addr,
  output logic              out_v,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ready,
  output logic              full,
  output logic [CNT_W-1:0]  count
`ifdef PFQ_STATS_EN
  ,
  output logic [STAT_W-1:0] dup_drops,
  output logic [STAT_W-1:0] full_drops,
  output logic [STAT_W-1:0] squashes
`endif
);

  // Handshake: a request transfers on a posedge where out_v && out_ready; out_v never
  // depends on out_ready, and out_addr stays stable while out_v && !out_ready.

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d, squash_q, squash_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] hold_q;

  logic [DEPTH-1:0]  pf_hit, dem_hit;
  logic              head_v, head_sq, pop, dup, dem_drop, full_drop, push;

  prefetch_queue_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dup_cam (
    .key_i        (pf_addr),
    .slot_addr_i  (addr_q),
    .slot_valid_i (valid_q),
    .hit_o        (pf_hit)
  );

  prefetch_queue_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_squash_cam (
    .key_i        (dem_addr),
    .slot_addr_i  (addr_q),
    .slot_valid_i (valid_q),
    .hit_o        (dem_hit)
  );

  assign head_v    = valid_q[head_q];
  assign head_sq   = squash_q[head_q];
  assign pop       = head_v && (head_sq || out_ready);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign dup       = |pf_hit;
  assign dem_drop  = dem_v && (dem_addr == pf_addr);
  assign full_drop = full && !pop;
  assign push      = pf_v && !dup && !dem_drop && !full_drop;

  assign out_v    = head_v && !head_sq;
  // When empty, the last presented address is held rather than a stale slot.
  assign out_addr = head_v ? addr_q[head_q] : hold_q;
  assign count    = count_q;

  // Squash first, then pop, then push: a push into a full queue reuses the popped slot.
  always_comb begin
    addr_d   = addr_q;
    valid_d  = valid_q;
    squash_d = squash_q;
    head_d   = head_q;
    tail_d   = tail_q;
    if (dem_v) begin
      squash_d = squash_q | dem_hit;
    end
    if (pop) begin
      valid_d[head_q]  = 1'b0;
      squash_d[head_q] = 1'b0;
      head_d           = head_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tail_q]  = 1'b1;
      squash_d[tail_q] = 1'b0;
      addr_d[tail_q]   = pf_addr;
      tail_d           = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
      valid_q  <= '0;
      squash_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      hold_q   <= out_addr;
    end
  end

`ifdef PFQ_STATS_EN
  logic [STAT_W-1:0] dup_cnt_q, full_cnt_q, sq_cnt_q;
  logic              dup_inc, full_inc, sq_inc;

  assign dup_inc  = pf_v && (dup || dem_drop);
  assign full_inc = pf_v && !dup && !dem_drop && full_drop;
  assign sq_inc   = pop && head_sq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_cnt_q  <= '0;
      full_cnt_q <= '0;
      sq_cnt_q   <= '0;
    end else begin
      if (dup_inc && (dup_cnt_q != '1))   dup_cnt_q  <= dup_cnt_q + STAT_W'(1);
      if (full_inc && (full_cnt_q != '1)) full_cnt_q <= full_cnt_q + STAT_W'(1);
      if (sq_inc && (sq_cnt_q != '1))     sq_cnt_q   <= sq_cnt_q + STAT_W'(1);
    end
  end

  assign dup_drops  = dup_cnt_q;
  assign full_drops = full_cnt_q;
  assign squashes   = sq_cnt_q;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a scoreboard of expected issue addresses.
// Build with PFQ_STATS_EN defined to also check the statistics counters.
module tb_prefetch_queue;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pf_v, dem_v, out_ready;
  logic [W-1:0]  pf_addr, dem_addr;
  logic          out_v, full;
  logic [W-1:0]  out_addr;
  logic [3:0]    count;
`ifdef PFQ_STATS_EN
  logic [15:0]   dup_drops, full_drops, squashes;
`endif

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            issued = 0;

  prefetch_queue #(.DEPTH(8), .ADDR_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pf_v      (pf_v),
    .pf_addr   (pf_addr),
    .dem_v     (dem_v),
    .dem_addr  (dem_addr),
    .out_v     (out_v),
    .out_addr  (out_addr),
    .out_ready (out_ready),
    .full      (full),
    .count     (count)
`ifdef PFQ_STATS_EN
    ,
    .dup_drops  (dup_drops),
    .full_drops (full_drops),
    .squashes   (squashes)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: hold inputs across one posedge, return 1 time unit after it.
  task automatic cyc(input logic pv, input logic [W-1:0] pa, input logic dv,
                     input logic [W-1:0] da, input logic rdy);
    pf_v      = pv;
    pf_addr   = pa;
    dem_v     = dv;
    dem_addr  = da;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, rdy);
  endtask

  // Monitor: every accepted issue must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_v && out_ready) begin
      issued++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got 0x%0h expected none", out_addr);
      end else begin
        chk("issue_addr", {16'h0, out_addr}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; pf_v = 1'b0; pf_addr = '0; dem_v = 1'b0; dem_addr = '0; out_ready = 1'b0;
    #2;
    chk("rst_out_v", {31'h0, out_v}, 0);
    chk("rst_count", {28'h0, count}, 0);
    chk("rst_full", {31'h0, full}, 0);
    chk("rst_out_addr", {16'h0, out_addr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: in-order issue, one cycle latency
    exp_q.push_back(16'h0010);
    cyc(1'b1, 16'h0010, 1'b0, '0, 1'b1);
    chk("t1_latency_v", {31'h0, out_v}, 1);
    chk("t1_latency_addr", {16'h0, out_addr}, 32'h0010);
    exp_q.push_back(16'h0011);
    cyc(1'b1, 16'h0011, 1'b0, '0, 1'b1);
    exp_q.push_back(16'h0012);
    cyc(1'b1, 16'h0012, 1'b0, '0, 1'b1);
    idle(1'b1, 2);
    chk("t1_count", {28'h0, count}, 0);
    chk("t1_empty_v", {31'h0, out_v}, 0);
    chk("t1_hold_addr", {16'h0, out_addr}, 32'h0012);

    // 2: duplicate drop
    exp_q.push_back(16'h0011);
    cyc(1'b1, 16'h0011, 1'b0, '0, 1'b0);
    exp_q.push_back(16'h0012);
    cyc(1'b1, 16'h0012, 1'b0, '0, 1'b0);
    cyc(1'b1, 16'h0011, 1'b0, '0, 1'b0);
    cyc(1'b1, 16'h0012, 1'b0, '0, 1'b0);
    chk("t2_count", {28'h0, count}, 2);
    chk("t2_hold_addr", {16'h0, out_addr}, 32'h0011);
`ifdef PFQ_STATS_EN
    chk("t2_dup_drops", {16'h0, dup_drops}, 2);
`endif
    idle(1'b1, 3);
    chk("t2_drained", {28'h0, count}, 0);

    // 3: fill, full drop, then push+pop while full
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(16'h0100 + 16'(i));
      cyc(1'b1, 16'h0100 + 16'(i), 1'b0, '0, 1'b0);
    end
    cyc(1'b1, 16'h0108, 1'b0, '0, 1'b0);
    chk("t3_full", {31'h0, full}, 1);
    chk("t3_count_full", {28'h0, count}, 8);
`ifdef PFQ_STATS_EN
    chk("t3_full_drops", {16'h0, full_drops}, 1);
`endif
    exp_q.push_back(16'h0109);
    cyc(1'b1, 16'h0109, 1'b0, '0, 1'b1);
    chk("t3_count_pushpop", {28'h0, count}, 8);
    chk("t3_next_head", {16'h0, out_addr}, 32'h0101);
    idle(1'b1, 10);
    chk("t3_drained", {28'h0, count}, 0);

    // 4: demand squash of queued head
    cyc(1'b1, 16'h0020, 1'b0, '0, 1'b0);
    exp_q.push_back(16'h0021);
    cyc(1'b1, 16'h0021, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, 16'h0020, 1'b0);
    chk("t4_squashed_v", {31'h0, out_v}, 0);
    chk("t4_squashed_count", {28'h0, count}, 2);
    idle(1'b0, 1);
    chk("t4_next_v", {31'h0, out_v}, 1);
    chk("t4_next_addr", {16'h0, out_addr}, 32'h0021);
    chk("t4_count", {28'h0, count}, 1);
`ifdef PFQ_STATS_EN
    chk("t4_squashes", {16'h0, squashes}, 1);
`endif
    idle(1'b1, 2);

    // 5: candidate equal to concurrent demand is dropped
    cyc(1'b1, 16'h0030, 1'b1, 16'h0030, 1'b1);
    chk("t5_count", {28'h0, count}, 0);
    chk("t5_out_v", {31'h0, out_v}, 0);
`ifdef PFQ_STATS_EN
    chk("t5_dup_drops", {16'h0, dup_drops}, 3);
`endif

    // 6: asynchronous reset between edges
    cyc(1'b1, 16'h0050, 1'b0, '0, 1'b0);
    cyc(1'b1, 16'h0051, 1'b0, '0, 1'b0);
    cyc(1'b1, 16'h0052, 1'b0, '0, 1'b0);
    chk("t6_count_before", {28'h0, count}, 3);
    pf_v = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_out_v", {31'h0, out_v}, 0);
    chk("t6_async_count", {28'h0, count}, 0);
`ifdef PFQ_STATS_EN
    chk("t6_stats_cleared", {16'h0, dup_drops}, 0);
`endif
    #1 rst = 1'b0;
    exp_q.push_back(16'h0040);
    cyc(1'b1, 16'h0040, 1'b0, '0, 1'b1);
    chk("t6_after_v", {31'h0, out_v}, 1);
    chk("t6_after_addr", {16'h0, out_addr}, 32'h0040);
    idle(1'b1, 2);
    chk("t6_count_end", {28'h0, count}, 0);

    // Final report
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("issued_total", issued, 16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
